// File: rtl/qpsk_mod.sv
// ============================================================================
// Module   : qpsk_mod
// Purpose  : Serial-bit to QPSK symbol mapper with ready/valid handshakes on
//            both sides; two bits (b0 -> I, b1 -> Q) form one Q1.15 symbol.
// Option   : define QPSK_MOD_BLOCK_CNT_EN to enable the per-block symbol
//            counter that drives last_out; otherwise last_out is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module qpsk_mod #(
    parameter logic signed [15:0] AMP         = 16'sd23170,
    parameter int                 SYM_PER_BLK = 96
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        data_in,
    input  logic        valid_in,
    output logic        ready_out,
    output logic [15:0] I_out,
    output logic [15:0] Q_out,
    output logic        valid_out,
    input  logic        ready_in,
    output logic        last_out
);

    localparam logic [0:0]  WAIT_I = 1'b0;
    localparam logic [0:0]  WAIT_Q = 1'b1;

    localparam logic [15:0] AMP_POS = AMP;
    localparam logic [15:0] AMP_NEG = -AMP;

    logic [0:0]  state_q, state_d;
    logic        b0_q, b0_d;
    logic        valid_q, valid_d;
    logic [15:0] i_q, i_d;
    logic [15:0] q_q, q_d;

    logic        ready_w;
    logic        in_xfer_w;
    logic        out_xfer_w;
    logic        b1_xfer_w;

    assign in_xfer_w  = valid_in && ready_w;
    assign out_xfer_w = valid_q && ready_in;
    assign b1_xfer_w  = in_xfer_w && (state_q == WAIT_Q);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= WAIT_I;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_I: if (in_xfer_w) state_d = WAIT_Q;
            WAIT_Q: if (in_xfer_w) state_d = WAIT_I;
            default: state_d = WAIT_I;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. The second bit may only enter once the output slot is
    // free or being drained this cycle, so a held symbol is never lost.
    // ------------------------------------------------------------------
    always_comb begin
        ready_w = 1'b0;
        if (resetN) begin
            case (state_q)
                WAIT_I:  ready_w = 1'b1;
                WAIT_Q:  ready_w = !valid_q || ready_in;
                default: ready_w = 1'b0;
            endcase
        end
    end

    assign ready_out = ready_w;

    // ------------------------------------------------------------------
    // Symbol datapath
    // ------------------------------------------------------------------
    always_comb begin
        b0_d    = b0_q;
        valid_d = valid_q;
        i_d     = i_q;
        q_d     = q_q;

        if (in_xfer_w && (state_q == WAIT_I)) begin
            b0_d = data_in;
        end

        if (b1_xfer_w) begin
            i_d     = b0_q    ? AMP_NEG : AMP_POS;
            q_d     = data_in ? AMP_NEG : AMP_POS;
            valid_d = 1'b1;
        end else if (out_xfer_w) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            b0_q    <= 1'b0;
            valid_q <= 1'b0;
            i_q     <= 16'd0;
            q_q     <= 16'd0;
        end else begin
            b0_q    <= b0_d;
            valid_q <= valid_d;
            i_q     <= i_d;
            q_q     <= q_d;
        end
    end

    assign I_out     = i_q;
    assign Q_out     = q_q;
    assign valid_out = valid_q;

`ifdef QPSK_MOD_BLOCK_CNT_EN
    localparam int               CNT_W    = (SYM_PER_BLK > 1) ? $clog2(SYM_PER_BLK) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_PER_BLK - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;

    // Counter indexes the symbol being formed; last tags it as it is loaded.
    always_comb begin
        cnt_d  = cnt_q;
        last_d = last_q;
        if (b1_xfer_w) begin
            last_d = (cnt_q == CNT_LAST);
            cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    assign last_out = last_q;
`else
    assign last_out = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_qpsk_mod.sv
// Testbench for qpsk_mod: scoreboard of expected symbols pushed on the second
// accepted bit and popped when the DUT hands a symbol downstream.
`default_nettype none

module tb_qpsk_mod;

    localparam int          SYM = 96;
    localparam logic [15:0] AP  = 16'd23170;
    localparam logic [15:0] AN  = 16'd42366;   // -23170 in 16-bit two's complement

    typedef struct packed {
        logic [15:0] i;
        logic [15:0] q;
        logic        last;
    } sym_t;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        data_in = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic [15:0] I_out;
    logic [15:0] Q_out;
    logic        valid_out;
    logic        ready_in = 1'b0;
    logic        last_out;

    qpsk_mod dut (
        .clk      (clk),
        .resetN   (resetN),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready_out(ready_out),
        .I_out    (I_out),
        .Q_out    (Q_out),
        .valid_out(valid_out),
        .ready_in (ready_in),
        .last_out (last_out)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    sym_t sb[$];
    logic m_half  = 1'b0;
    logic m_b0    = 1'b0;
    logic m_valid = 1'b0;
    int   m_cnt   = 0;
    int   n_out   = 0;
    int   n_last  = 0;
    int   n_acc   = 0;

    function automatic logic [15:0] map_bit(input logic b);
        return b ? AN : AP;
    endfunction

    function automatic logic exp_last(input int cnt);
`ifdef QPSK_MOD_BLOCK_CNT_EN
        return (cnt == SYM - 1);
`else
        return 1'b0;
`endif
    endfunction

    // One clock of stimulus: drive at the falling edge, check the outputs that
    // the previous rising edge produced, then advance the reference model.
    task automatic drive(input logic vin, input logic din, input logic rin);
        logic exp_rdy, acc, out_x, was_half;
        sym_t obs;
        @(negedge clk);
        valid_in = vin;
        data_in  = din;
        ready_in = rin;
        #1;
        exp_rdy = !m_half || !m_valid || rin;
        total++;
        if (ready_out !== exp_rdy) begin
            bad++;
            $display("FAIL ready_out: got %b want %b at %0t", ready_out, exp_rdy, $time);
        end
        total++;
        if (valid_out !== m_valid) begin
            bad++;
            $display("FAIL valid_out: got %b want %b at %0t", valid_out, m_valid, $time);
        end
        if (m_valid) begin
            obs = '{i: I_out, q: Q_out, last: last_out};
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_empty: got symbol %h want none at %0t", obs, $time);
            end else if (obs !== sb[0]) begin
                bad++;
                $display("FAIL symbol: got I=%h Q=%h last=%b want I=%h Q=%h last=%b at %0t",
                         obs.i, obs.q, obs.last, sb[0].i, sb[0].q, sb[0].last, $time);
            end
        end
        out_x    = m_valid && rin;
        acc      = vin && exp_rdy;
        was_half = m_half;
        if (out_x) begin
            if (sb.size() != 0) begin
                if (sb[0].last) n_last++;
                void'(sb.pop_front());
            end
            n_out++;
        end
        if (acc) begin
            n_acc++;
            if (!m_half) begin
                m_b0   = din;
                m_half = 1'b1;
            end else begin
                sb.push_back('{i: map_bit(m_b0), q: map_bit(din), last: exp_last(m_cnt)});
                m_cnt  = (m_cnt == SYM - 1) ? 0 : m_cnt + 1;
                m_half = 1'b0;
            end
        end
        if (acc && was_half) m_valid = 1'b1;
        else if (out_x)      m_valid = 1'b0;
    endtask

    task automatic model_reset();
        sb.delete();
        m_half  = 1'b0;
        m_b0    = 1'b0;
        m_valid = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic drain();
        for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        @(negedge clk);
        resetN   = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b0;
        #1;
        total++;
        if ({valid_out, last_out, ready_out, I_out, Q_out} !== 35'd0) begin
            bad++;
            $display("FAIL reset_state: got v=%b l=%b r=%b I=%h Q=%h want all 0",
                     valid_out, last_out, ready_out, I_out, Q_out);
        end
        model_reset();
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (ready_out !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_reset: got %b want 1", ready_out);
        end
    endtask

    task automatic test_first_symbol();
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        total++;
        if ({valid_out, I_out, Q_out} !== {1'b1, AP, AP}) begin
            bad++;
            $display("FAIL first_symbol: got v=%b I=%h Q=%h want v=1 I=%h Q=%h",
                     valid_out, I_out, Q_out, AP, AP);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [6:0] bits = 7'b1001110;   // MSB first: 1,0,0,1,1,1 then idle
        logic [6:0] seen;
        for (int k = 0; k < 7; k++) begin
            drive(k < 6, bits[6-k], 1'b1);
            seen[6-k] = valid_out;
        end
        total++;
        if (seen !== 7'b0010101) begin
            bad++;
            $display("FAIL b2b_valid_pattern: got %b want 0010101", seen);
        end
        drain();
        total++;
        if ({valid_out, I_out, Q_out} !== {1'b0, AN, AN}) begin
            bad++;
            $display("FAIL idle_retain: got v=%b I=%h Q=%h want v=0 I=%h Q=%h",
                     valid_out, I_out, Q_out, AN, AN);
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);     // symbol (+A,-A) formed
        drive(1'b1, 1'b1, 1'b0);     // b0 of next symbol accepted
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 1'b0);
            total++;
            if ({ready_out, valid_out, I_out, Q_out} !== {1'b0, 1'b1, AP, AN}) begin
                bad++;
                $display("FAIL stall_hold: got r=%b v=%b I=%h Q=%h want r=0 v=1 I=%h Q=%h",
                         ready_out, valid_out, I_out, Q_out, AP, AN);
            end
        end
        drive(1'b1, 1'b0, 1'b1);     // drain and replace in one cycle
        drive(1'b0, 1'b0, 1'b0);
        total++;
        if ({valid_out, I_out, Q_out} !== {1'b1, AN, AP}) begin
            bad++;
            $display("FAIL stall_replace: got v=%b I=%h Q=%h want v=1 I=%h Q=%h",
                     valid_out, I_out, Q_out, AN, AP);
        end
        drain();
    endtask

    task automatic test_block();
        int exp_last_cnt;
        test_reset();
        n_out  = 0;
        n_last = 0;
        for (int k = 0; k < 2 * SYM; k++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b1);
        drain();
        total++;
        if (n_out !== SYM) begin
            bad++;
            $display("FAIL block_symbols: got %0d want %0d", n_out, SYM);
        end
`ifdef QPSK_MOD_BLOCK_CNT_EN
        exp_last_cnt = 1;
`else
        exp_last_cnt = 0;
`endif
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        drain();
        total++;
        if (n_last !== exp_last_cnt) begin
            bad++;
            $display("FAIL block_last_count: got %0d want %0d", n_last, exp_last_cnt);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);     // symbol pending, not drained
        drive(1'b1, 1'b0, 1'b0);     // b0 stored
        #2;
        resetN = 1'b0;
        #1;
        total++;
        if ({valid_out, ready_out, last_out} !== 3'b000) begin
            bad++;
            $display("FAIL reset_mid: got v=%b r=%b l=%b want 000", valid_out, ready_out, last_out);
        end
        model_reset();
        valid_in = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        total++;
        if ({valid_out, I_out, Q_out} !== {1'b1, AN, AN}) begin
            bad++;
            $display("FAIL reset_mid_symbol: got v=%b I=%h Q=%h want v=1 I=%h Q=%h",
                     valid_out, I_out, Q_out, AN, AN);
        end
        drain();
    endtask

    task automatic test_random();
        int cycles = 0;
        n_acc = 0;
        while (n_acc < 1920 && cycles < 30000) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 2) != 0));
            cycles++;
        end
        total++;
        if (n_acc < 1920) begin
            bad++;
            $display("FAIL random_budget: got %0d bits want 1920", n_acc);
        end
        drain();
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("FAIL random_leftover: got %0d pending want 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_first_symbol();
        test_back_to_back();
        test_stall();
        test_block();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
